int_to_bfloat_conv: RTL and testbench

- Multi-cycle encoder that converts a signed two's-complement integer into a bfloat16 value (1 sign, 8 exponent with bias 127, 7 mantissa bits).
- Produces operands in the same format the bfloat16 add/sub datapath consumes, for example for loading integer accumulator seeds or bias terms into the MAC.
- Normalization is serial: one left shift per cycle.
- Valid/ready handshakes are used on both input and output.

---
 rtl/int_to_bfloat_conv_if.sv | 22 ++
 rtl/int_to_bfloat_conv.sv | 104 ++++++++++
 tb/tb_int_to_bfloat_conv.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/int_to_bfloat_conv_if.sv
// Valid/ready handshake bundle for the integer-to-bfloat16 encoder.
// The input side carries a signed integer and the output side carries the bfloat16 result.
interface int_to_bfloat_conv_if #(
  parameter int IN_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [15:0]     out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/int_to_bfloat_conv.sv
// Serial int -> bfloat16 encoder: one normalising shift per cycle, then
// round-to-nearest-even, then hold the result until it is accepted.
//
// state | meaning
// IDLE  | waiting for an input, in_ready high
// NORM  | shift magnitude left until its MSB is set
// ROUND | round the mantissa to nearest-even and register the result
// DONE  | out_valid high, result held until out_ready
module int_to_bfloat_conv #(
  parameter int IN_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  int_to_bfloat_conv_if.slave bus,
  output logic                busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [7:0] EXP_INIT = 8'(127 + IN_W - 1);

  logic [1:0]      state;
  logic            sign;
  logic [IN_W-1:0] mag;
  logic [7:0]      expo;
  logic [15:0]     result;

  logic [IN_W-1:0] abs_in;
  logic [6:0]      mant;
  logic            guard;
  logic            sticky;
  logic            round_up;
  logic [7:0]      mant_inc;
  logic [7:0]      exp_rnd;

  // Most-negative input negates to 2^(IN_W-1), which still fits unsigned.
  assign abs_in = bus.in_data[IN_W-1] ? (~bus.in_data + IN_W'(1)) : bus.in_data;

  assign mant  = mag[IN_W-2:IN_W-8];
  assign guard = mag[IN_W-9];

  generate
    if (IN_W > 9) begin : g_sticky
      assign sticky = |mag[IN_W-10:0];
    end else begin : g_no_sticky
      assign sticky = 1'b0;
    end
  endgenerate

  assign round_up = guard & (sticky | mant[0]);
  assign mant_inc = {1'b0, mant} + 8'(round_up);
  assign exp_rnd  = expo + 8'(mant_inc[7]);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = result;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sign   <= 1'b0;
      mag    <= '0;
      expo   <= 8'd0;
      result <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign <= bus.in_data[IN_W-1];
            mag  <= abs_in;
            expo <= EXP_INIT;
            if (abs_in == '0) begin
              result <= 16'h0000;
              state  <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (!mag[IN_W-1]) begin
            mag  <= mag << 1;
            expo <= expo - 8'd1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          // A carry out of the mantissa leaves mant_inc[6:0] at zero.
          result <= {sign, exp_rnd, mant_inc[6:0]};
          state  <= DONE;
        end
        default: begin
          if (bus.out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_bfloat_conv.sv
// Directed self-checking bench for int_to_bfloat_conv at IN_W=16.
// Latency is counted as rising edges after the accept edge until out_valid is seen.
module tb_int_to_bfloat_conv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   n_cmp = 0;
  int   n_err = 0;

  int_to_bfloat_conv_if #(.IN_W(16)) bus ();

  int_to_bfloat_conv #(.IN_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one input, wait for acceptance, measure latency, check result, then drain.
  task automatic convert(input logic [15:0] v, input logic [15:0] expd, input int exp_lat, input string tag);
    int g;
    int lat;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = v;
    bus.out_ready = 1'b0;
    g = 0;
    while (!bus.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_accept_timeout"}, 32'(g < 200), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, 32'(bus.out_data), 32'(expd));
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_release"}, 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] held;
    int g;
    int n_out;
    logic [15:0] stream_in  [3];
    logic [15:0] stream_exp [3];

    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data", 32'(bus.out_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);

    // Abort mid-NORM with a reset pulse.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_out_data", 32'(bus.out_data), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_no_result", 32'(bus.out_valid), 32'd0);

    convert(16'd1,      16'h3F80, 17, "one");
    convert(16'hFFFF,   16'hBF80, 17, "minus_one");
    convert(16'd3,      16'h4040, 16, "three");
    convert(16'd0,      16'h0000, 0,  "zero");
    convert(16'd32767,  16'h4700, 3,  "max_pos");
    convert(16'h8000,   16'hC700, 2,  "max_neg");
    convert(16'd257,    16'h4380, 9,  "tie_even");
    convert(16'd259,    16'h4382, 9,  "tie_odd");
    convert(16'd383,    16'h43C0, 9,  "carry_bit6");

    // Backpressure: hold the result while in_valid pulses with other data.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'd3;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    g = 0;
    while (!bus.out_valid && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("bp_wait", 32'(g), 32'd16);
    held = bus.out_data;
    check("bp_first", 32'(held), 32'h4040);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.in_data  = 16'(16'd100 + 16'(i));
      @(posedge clk); #1;
      check("bp_stable", 32'(bus.out_data), 32'h4040);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_valid", 32'(bus.out_valid), 32'd0);
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_data", 32'(bus.out_data), 32'h4040);
    bus.out_ready = 1'b0;
    convert(16'd4, 16'h4080, 15, "after_bp");

    // Back-to-back stream with out_ready held high and in_valid never dropped.
    stream_in  = '{16'd1, 16'd2, 16'd4};
    stream_exp = '{16'h3F80, 16'h4000, 16'h4080};
    n_out = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = stream_in[0];
    for (int k = 0; k < 3; k++) begin
      g = 0;
      while (!bus.out_valid && g < 200) begin
        @(negedge clk);
        g++;
      end
      check("stream_timeout", 32'(g < 200), 32'd1);
      check("stream_data", 32'(bus.out_data), 32'(stream_exp[k]));
      check("stream_in_ready", 32'(bus.in_ready), 32'd0);
      n_out++;
      if (k < 2) bus.in_data = stream_in[k+1];
      else bus.in_valid = 1'b0;
      @(negedge clk);
      check("stream_idle", 32'(bus.in_ready), 32'(k < 2 ? 1 : 1));
    end
    bus.out_ready = 1'b1;
    repeat (40) @(negedge clk);
    check("stream_no_extra", 32'(bus.out_valid), 32'd0);
    check("stream_count", 32'(n_out), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
